// File: rtl/csr_trap_unit.sv
// csr_trap_unit: trap entry / trap return for the CSR stage.
// Selects the highest-priority enabled interrupt or exception, decides whether it
// is delegated to S-mode, updates mstatus/xepc/xcause/xtval/privilege one cycle
// later and produces a registered one-cycle redirect pulse.
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   instValid, pc, tval   committing instruction, its PC and fault value
//   raiseExceptionVec     one bit per exception cause code
//   intrPending           interrupts already masked by mie
//   mideleg/medeleg       delegation masks; mtvec/stvec trap vectors; uepc uRet target
//   uRet/sRet/mRet        xRET decoded
//   csrWen/Addr/Wdata     software CSR write port
//   mstatus..stval        architectural registers
//   priviledgeMode        current privilege
//   raiseTrap/raiseIntr/causeNO  combinational trap decision
//   redirectValid/Target  registered fetch redirect
module csr_trap_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned EXC_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instValid,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  tval,
  input  logic [EXC_W-1:0] raiseExceptionVec,
  input  logic [11:0]      intrPending,
  input  logic [XLEN-1:0]  mideleg,
  input  logic [XLEN-1:0]  medeleg,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  stvec,
  input  logic [XLEN-1:0]  uepc,
  input  logic             uRet,
  input  logic             sRet,
  input  logic             mRet,
  input  logic             csrWen,
  input  logic [11:0]      csrAddr,
  input  logic [XLEN-1:0]  csrWdata,
  output logic [XLEN-1:0]  mstatus,
  output logic [XLEN-1:0]  mepc,
  output logic [XLEN-1:0]  mcause,
  output logic [XLEN-1:0]  mtval,
  output logic [XLEN-1:0]  sepc,
  output logic [XLEN-1:0]  scause,
  output logic [XLEN-1:0]  stval,
  output logic [1:0]       priviledgeMode,
  output logic             raiseTrap,
  output logic             raiseIntr,
  output logic [XLEN-1:0]  causeNO,
  output logic             redirectValid,
  output logic [XLEN-1:0]  redirectTarget
);

  localparam logic [XLEN-1:0] MstatusMask  = XLEN'(64'h0000_0000_000C_19BB);
  // SXL and UXL hard-wired to 2'b10 (64-bit)
  localparam logic [XLEN-1:0] MstatusFixed = XLEN'(64'h0000_000A_0000_0000);

  localparam logic [1:0] PrivU = 2'b00;
  localparam logic [1:0] PrivS = 2'b01;
  localparam logic [1:0] PrivM = 2'b11;

  // mstatus bit positions
  localparam int unsigned BitUie  = 0;
  localparam int unsigned BitSie  = 1;
  localparam int unsigned BitMie  = 3;
  localparam int unsigned BitUpie = 4;
  localparam int unsigned BitSpie = 5;
  localparam int unsigned BitMpie = 7;
  localparam int unsigned BitSpp  = 8;

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] sepc_q, sepc_d, scause_q, scause_d, stval_q, stval_d;
  logic [1:0]      priv_q, priv_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_target_q, redirect_target_d;

  logic            m_ok, s_ok;
  logic            intr_any, exc_any, is_intr, trap_take, to_s;
  logic [3:0]      intr_code, exc_code, code;
  logic [XLEN-1:0] deleg, tvec, trap_target, mstatus_wr;

  // Codes with no defined priority are never selected.
  logic unused_codes;
  assign unused_codes = ^{raiseExceptionVec[10], raiseExceptionVec[14],
                          intrPending[2], intrPending[6], intrPending[10]};

  // Interrupt enables and priority 11>3>7>9>1>5>8>0>4
  always_comb begin
    m_ok      = (priv_q != PrivM) || mstatus_q[BitMie];
    s_ok      = (priv_q == PrivU) || ((priv_q == PrivS) && mstatus_q[BitSie]);
    intr_any  = 1'b1;
    intr_code = 4'd0;
    if      (intrPending[11] && m_ok) intr_code = 4'd11;
    else if (intrPending[3]  && m_ok) intr_code = 4'd3;
    else if (intrPending[7]  && m_ok) intr_code = 4'd7;
    else if (intrPending[9]  && s_ok) intr_code = 4'd9;
    else if (intrPending[1]  && s_ok) intr_code = 4'd1;
    else if (intrPending[5]  && s_ok) intr_code = 4'd5;
    else if (intrPending[8]  && m_ok) intr_code = 4'd8;
    else if (intrPending[0]  && m_ok) intr_code = 4'd0;
    else if (intrPending[4]  && m_ok) intr_code = 4'd4;
    else                              intr_any  = 1'b0;
  end

  // Exception priority 3>12>1>2>0>8>9>11>6>4>15>13>7>5
  always_comb begin
    exc_any  = 1'b1;
    exc_code = 4'd0;
    if      (raiseExceptionVec[3])  exc_code = 4'd3;
    else if (raiseExceptionVec[12]) exc_code = 4'd12;
    else if (raiseExceptionVec[1])  exc_code = 4'd1;
    else if (raiseExceptionVec[2])  exc_code = 4'd2;
    else if (raiseExceptionVec[0])  exc_code = 4'd0;
    else if (raiseExceptionVec[8])  exc_code = 4'd8;
    else if (raiseExceptionVec[9])  exc_code = 4'd9;
    else if (raiseExceptionVec[11]) exc_code = 4'd11;
    else if (raiseExceptionVec[6])  exc_code = 4'd6;
    else if (raiseExceptionVec[4])  exc_code = 4'd4;
    else if (raiseExceptionVec[15]) exc_code = 4'd15;
    else if (raiseExceptionVec[13]) exc_code = 4'd13;
    else if (raiseExceptionVec[7])  exc_code = 4'd7;
    else if (raiseExceptionVec[5])  exc_code = 4'd5;
    else                            exc_any  = 1'b0;
  end

  always_comb begin
    is_intr     = instValid && intr_any;
    trap_take   = instValid && (intr_any || exc_any);
    code        = intr_any ? intr_code : exc_code;
    deleg       = intr_any ? mideleg : medeleg;
    to_s        = deleg[code] && (priv_q != PrivM);
    tvec        = to_s ? stvec : mtvec;
    trap_target = {tvec[XLEN-1:2], 2'b00};
    if (tvec[0] && intr_any) begin
      trap_target = trap_target + {{(XLEN-6){1'b0}}, code, 2'b00};
    end
  end

  assign raiseTrap = trap_take;
  assign raiseIntr = is_intr;
  assign causeNO   = {intr_any, {(XLEN-5){1'b0}}, code};

  // Masked software mstatus write; the reserved MPP encoding keeps the old value.
  always_comb begin
    mstatus_wr = csrWdata & MstatusMask;
    if (csrWdata[12:11] == 2'b10) begin
      mstatus_wr[12:11] = mstatus_q[12:11];
    end
  end

  always_comb begin
    mstatus_d         = mstatus_q;
    mepc_d            = mepc_q;
    mcause_d          = mcause_q;
    mtval_d           = mtval_q;
    sepc_d            = sepc_q;
    scause_d          = scause_q;
    stval_d           = stval_q;
    priv_d            = priv_q;
    redirect_valid_d  = 1'b0;
    redirect_target_d = redirect_target_q;

    if (trap_take) begin
      redirect_valid_d  = 1'b1;
      redirect_target_d = trap_target;
      if (to_s) begin
        scause_d           = causeNO;
        sepc_d             = pc;
        stval_d            = intr_any ? '0 : tval;
        mstatus_d[BitSpie] = mstatus_q[BitSie];
        mstatus_d[BitSie]  = 1'b0;
        mstatus_d[BitSpp]  = priv_q[0];
        priv_d             = PrivS;
      end else begin
        mcause_d           = causeNO;
        mepc_d             = pc;
        mtval_d            = intr_any ? '0 : tval;
        mstatus_d[BitMpie] = mstatus_q[BitMie];
        mstatus_d[BitMie]  = 1'b0;
        mstatus_d[12:11]   = priv_q;
        priv_d             = PrivM;
      end
    end else if (instValid && mRet) begin
      redirect_valid_d   = 1'b1;
      redirect_target_d  = mepc_q;
      mstatus_d[BitMie]  = mstatus_q[BitMpie];
      mstatus_d[BitMpie] = 1'b1;
      mstatus_d[12:11]   = PrivU;
      priv_d             = mstatus_q[12:11];
    end else if (instValid && sRet) begin
      redirect_valid_d   = 1'b1;
      redirect_target_d  = sepc_q;
      mstatus_d[BitSie]  = mstatus_q[BitSpie];
      mstatus_d[BitSpie] = 1'b1;
      mstatus_d[BitSpp]  = 1'b0;
      priv_d             = {1'b0, mstatus_q[BitSpp]};
    end else if (instValid && uRet) begin
      redirect_valid_d   = 1'b1;
      redirect_target_d  = uepc;
      mstatus_d[BitUie]  = mstatus_q[BitUpie];
      mstatus_d[BitUpie] = 1'b1;
      priv_d             = PrivU;
    end else if (instValid && csrWen) begin
      case (csrAddr)
        12'h300: mstatus_d = mstatus_wr;
        12'h341: mepc_d    = {csrWdata[XLEN-1:2], 2'b00};
        12'h342: mcause_d  = csrWdata;
        12'h343: mtval_d   = csrWdata;
        12'h141: sepc_d    = {csrWdata[XLEN-1:2], 2'b00};
        12'h142: scause_d  = csrWdata;
        12'h143: stval_d   = csrWdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_q         <= '0;
      mepc_q            <= '0;
      mcause_q          <= '0;
      mtval_q           <= '0;
      sepc_q            <= '0;
      scause_q          <= '0;
      stval_q           <= '0;
      priv_q            <= PrivM;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
    end else begin
      mstatus_q         <= mstatus_d;
      mepc_q            <= mepc_d;
      mcause_q          <= mcause_d;
      mtval_q           <= mtval_d;
      sepc_q            <= sepc_d;
      scause_q          <= scause_d;
      stval_q           <= stval_d;
      priv_q            <= priv_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_target_q <= redirect_target_d;
    end
  end

  assign mstatus        = (mstatus_q & MstatusMask) | MstatusFixed;
  assign mepc           = mepc_q;
  assign mcause         = mcause_q;
  assign mtval          = mtval_q;
  assign sepc           = sepc_q;
  assign scause         = scause_q;
  assign stval          = stval_q;
  assign priviledgeMode = priv_q;
  assign redirectValid  = redirect_valid_q;
  assign redirectTarget = redirect_target_q;

endmodule
